// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction codes and length helpers shared by the encoder and fetch decoder
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {S_IDLE, S_EMIT} enc_state_t;

    // Encoded length in bytes; 0 marks an illegal icode.
    function automatic logic [3:0] inst_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                  return 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      return 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          return 4'd10;
            I_JXX, I_CALL:                         return 4'd9;
            default:                               return 4'd0;
        endcase
    endfunction

    function automatic logic has_regbyte(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:                return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic has_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:                         return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_inst_encoder_if.sv
// rtl/y86_inst_encoder_if.sv - decoded-instruction handshake between sequencer and encoder
interface y86_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;

    modport master (output in_valid, icode, ifun, rA, rB, valC, input in_ready);
    modport slave  (input in_valid, icode, ifun, rA, rB, valC, output in_ready);
endinterface

// File: rtl/y86_byte_serializer.sv
// rtl/y86_byte_serializer.sv - emits a latched up-to-10-byte image one byte per clock, LSB byte first
module y86_byte_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        abort,
    input  logic [79:0] bytes,
    input  logic [3:0]  len,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        done,
    output logic        last
);
    logic [71:0] rest_q;
    logic [3:0]  rem_q;

    assign last = mem_we && (rem_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            rest_q    <= '0;
            rem_q     <= 4'd0;
        end else if (abort) begin
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            rem_q     <= 4'd0;
        end else if (load) begin
            mem_we    <= 1'b1;
            mem_wdata <= bytes[7:0];
            rest_q    <= bytes[79:8];
            rem_q     <= len - 4'd1;
            done      <= (len == 4'd1);
        end else if (mem_we) begin
            if (rem_q == 4'd0) begin
                mem_we    <= 1'b0;
                mem_wdata <= 8'h00;
                done      <= 1'b0;
            end else begin
                mem_wdata <= rest_q[7:0];
                rest_q    <= {8'h00, rest_q[71:8]};
                rem_q     <= rem_q - 4'd1;
                done      <= (rem_q == 4'd1);
            end
        end
    end
endmodule

// File: rtl/y86_inst_encoder.sv
// rtl/y86_inst_encoder.sv - Y86-64 instruction encoder/loader; Y86_ENC_RNONE_FILL_EN forces unused register nibbles to RNONE
module y86_inst_encoder
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ptr_clr,
    y86_inst_encoder_if.slave inst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              err_invalid,
    output logic              err_overflow
);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

    enc_state_t  state_q, state_d;
    logic [3:0]  len;
    logic [3:0]  ra_eff, rb_eff;
    logic [79:0] bytes;
    logic        fits;
    logic        load, abort, step, last, set_inv, set_ovf;

    assign len = inst_len(inst.icode);

`ifdef Y86_ENC_RNONE_FILL_EN
    assign ra_eff = (inst.icode == I_IRMOVQ) ? RNONE : inst.rA;
    assign rb_eff = (inst.icode == I_PUSHQ || inst.icode == I_POPQ) ? RNONE : inst.rB;
`else
    assign ra_eff = inst.rA;
    assign rb_eff = inst.rB;
`endif

    // Jumps and calls have no register byte, so valC moves up to byte 1.
    assign bytes = has_regbyte(inst.icode) ? {inst.valC, ra_eff, rb_eff, inst.icode, inst.ifun}
                                           : {8'h00, inst.valC, inst.icode, inst.ifun};

    assign fits = ({1'b0, wr_ptr} + {{(ADDR_W-3){1'b0}}, len}) <= DEPTH;
    assign inst.in_ready = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        abort   = 1'b0;
        step    = 1'b0;
        set_inv = 1'b0;
        set_ovf = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ptr_clr && inst.in_valid) begin
                    if (len == 4'd0) begin
                        set_inv = 1'b1;
                    end else if (!fits) begin
                        set_ovf = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (ptr_clr) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // wr_ptr advances as each byte is issued, so it is the next free address once idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= BASE;
            mem_addr     <= '0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (ptr_clr) begin
            wr_ptr       <= BASE;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (load) begin
                mem_addr <= wr_ptr;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (step) begin
                mem_addr <= mem_addr + 1'b1;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (set_inv) err_invalid  <= 1'b1;
            if (set_ovf) err_overflow <= 1'b1;
        end
    end

    y86_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .abort     (abort),
        .bytes     (bytes),
        .len       (len),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .done      (done),
        .last      (last)
    );
endmodule

// File: tb/tb_y86_inst_encoder.sv
// tb/tb_y86_inst_encoder.sv - directed self-checking bench for y86_inst_encoder
module tb_y86_inst_encoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ptr_clr;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       done;
    logic [9:0] wr_ptr;
    logic       err_invalid;
    logic       err_overflow;

    y86_inst_encoder_if ifc ();

    y86_inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ptr_clr      (ptr_clr),
        .inst         (ifc),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .done         (done),
        .wr_ptr       (wr_ptr),
        .err_invalid  (err_invalid),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:1023];
    int         we_cnt = 0;
    int         done_cnt = 0;
    logic [9:0] done_addr = '0;

    always @(posedge clk) begin
        if (mem_we) begin
            rom[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_addr <= mem_addr;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_irm [10] = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] exp_seq [12] = '{8'h00, 8'h10, 8'h90, 8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc);
        int n = 0;
        while (!ifc.in_ready && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40) check("ready_timeout", 64'(ifc.in_ready), 64'd1);
        ifc.icode    = ic;
        ifc.ifun     = fn;
        ifc.rA       = ra;
        ifc.rB       = rb;
        ifc.valC     = vc;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                        input int exp_busy);
        int n = 0;
        offer(ic, fn, ra, rb, vc);
        while (!ifc.in_ready && n < 20) begin
            n++;
            tick();
        end
        check({"busy_", tag}, 64'(n), 64'(exp_busy));
    endtask

    initial begin
        int we0;
        int done0;
        rst_n        = 1'b0;
        ptr_clr      = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.icode    = 4'h0;
        ifc.ifun     = 4'h0;
        ifc.rA       = 4'h0;
        ifc.rB       = 4'h0;
        ifc.valC     = 64'h0;
        #3;
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("rst_err_inv", 64'(err_invalid), 64'd0);
        check("rst_err_ovf", 64'(err_overflow), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // irmovq $0x0123456789ABCDEF, %rbx
        send("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 10);
        for (int i = 0; i < 10; i++) check($sformatf("irm_byte%0d", i), 64'(rom[i]), 64'(exp_irm[i]));
        check("irm_done_cnt", 64'(done_cnt), 64'd1);
        check("irm_done_addr", 64'(done_addr), 64'd9);
        check("irm_wr_ptr", 64'(wr_ptr), 64'd10);

        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        check("clr_wr_ptr", 64'(wr_ptr), 64'd0);
        send("halt", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1);
        send("nop",  4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1);
        send("ret",  4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1);
        send("jmp",  4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 9);
        for (int i = 0; i < 12; i++) check($sformatf("seq_byte%0d", i), 64'(rom[i]), 64'(exp_seq[i]));
        check("seq_wr_ptr", 64'(wr_ptr), 64'd12);

        we0 = we_cnt;
        send("inv", 4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 0);
        tick();
        check("inv_err", 64'(err_invalid), 64'd1);
        check("inv_no_write", 64'(we_cnt), 64'(we0));
        send("addq", 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 2);
        check("addq_b0", 64'(rom[12]), 64'h60);
        check("addq_b1", 64'(rom[13]), 64'h23);
        check("addq_err_sticky", 64'(err_invalid), 64'd1);
        check("addq_wr_ptr", 64'(wr_ptr), 64'd14);

        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        check("clr_err_inv", 64'(err_invalid), 64'd0);
        for (int i = 0; i < 102; i++) send("fill", 4'h3, 4'h0, 4'hF, 4'h1, 64'(i), 10);
        check("fill_wr_ptr", 64'(wr_ptr), 64'd1020);
        we0 = we_cnt;
        send("rmmovq_ovf", 4'h4, 4'h0, 4'h1, 4'h2, 64'h8, 0);
        tick();
        check("ovf_err", 64'(err_overflow), 64'd1);
        check("ovf_no_write", 64'(we_cnt), 64'(we0));
        check("ovf_wr_ptr", 64'(wr_ptr), 64'd1020);
        send("pushq", 4'hA, 4'h0, 4'h0, 4'h0, 64'h0, 2);
        check("push_b0", 64'(rom[1020]), 64'hA0);
`ifdef Y86_ENC_RNONE_FILL_EN
        check("push_b1", 64'(rom[1021]), 64'h0F);
`else
        check("push_b1", 64'(rom[1021]), 64'h00);
`endif
        send("popq_exact", 4'hB, 4'h0, 4'h5, 4'h7, 64'h0, 2);
        check("pop_b0", 64'(rom[1022]), 64'hB0);
`ifdef Y86_ENC_RNONE_FILL_EN
        check("pop_b1", 64'(rom[1023]), 64'h5F);
`else
        check("pop_b1", 64'(rom[1023]), 64'h57);
`endif
        check("wrap_wr_ptr", 64'(wr_ptr), 64'd0);
        send("rmmovq_wrap", 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122, 10);
        check("wrap_b0", 64'(rom[0]), 64'h40);
        check("wrap_b1", 64'(rom[1]), 64'h12);
        check("wrap_b2", 64'(rom[2]), 64'h22);
        check("wrap_b3", 64'(rom[3]), 64'h11);
        check("wrap_wr_ptr2", 64'(wr_ptr), 64'd10);

        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        done0 = done_cnt;
        offer(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
        tick();
        tick();
        check("call_b2_we", 64'(mem_we), 64'd1);
        check("call_b2_addr", 64'(mem_addr), 64'd2);
        ptr_clr = 1'b1;
        tick();
        ptr_clr = 1'b0;
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_ready", 64'(ifc.in_ready), 64'd1);
        check("abort_wr_ptr", 64'(wr_ptr), 64'd0);
        tick();
        check("abort_no_done", 64'(done_cnt), 64'(done0));

        offer(4'h3, 4'h0, 4'hF, 4'h3, 64'h55);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_we", 64'(mem_we), 64'd0);
        check("arst_addr", 64'(mem_addr), 64'd0);
        check("arst_wdata", 64'(mem_wdata), 64'd0);
        check("arst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("arst_ready", 64'(ifc.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send("rrmovq", 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 2);
        check("post_rst_b0", 64'(rom[0]), 64'h20);
        check("post_rst_b1", 64'(rom[1]), 64'h12);
        check("post_rst_wr_ptr", 64'(wr_ptr), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
